// File: rtl/wb_mux_seq.sv
// wb_mux_seq -- registered Wishbone splitter for the Caravel user area.
//
// Decodes Wishbone cycles into four channels chosen by the top two address
// bits: 00 programmer, 01 pads/soft-reset, 10 debugger, 11 entropy pool.
// A transaction FSM (IDLE -> ISSUE -> [WAIT] -> ACK) latches the request and
// drives every channel output from that request register, not from the live bus.
// Entropy writes are queued in a small circular FIFO. The pool drains it
// through a valid/ready handshake and can back-pressure the bus by leaving
// ready low.
//
// Optional feature macro: WB_MUX_TIMEOUT_EN. When defined, a debugger wait or
// an entropy stall that lasts TIMEOUT cycles is forced to ACK with all-ones
// data. Any entropy push still pending at that point is dropped.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_*                       Wishbone slave (stb/cyc/we/adr/dat in, ack/dat out)
//   prog_*                      programmer write strobe, core select, address, data
//   pads_*                      pads write strobe, address bit, data
//   debug_*                     debugger select/address, write/read strobes, data
//   entropy_valid/ready/word    entropy FIFO head and drain handshake
module wb_mux_seq #(
    parameter int LOG_CORES     = 3,
    parameter int PC_WIDTH      = 8,
    parameter int INSTR_WIDTH   = 32,
    parameter int DATA_WIDTH    = 16,
    parameter int IO_PINS       = 16,
    parameter int WB_WIDTH      = 32,
    parameter int READ_LAT      = 1,
    parameter int LOG_ENT_DEPTH = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [WB_WIDTH-1:0]      wbs_adr_i,
    input  logic [WB_WIDTH-1:0]      wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [WB_WIDTH-1:0]      wbs_dat_o,
    output logic                     prog_we,
    output logic [LOG_CORES-1:0]     prog_sel,
    output logic [PC_WIDTH-1:0]      prog_waddr,
    output logic [INSTR_WIDTH-1:0]   prog_wdata,
    output logic                     pads_we,
    output logic                     pads_waddr,
    output logic [IO_PINS-1:0]       pads_wdata,
    output logic [LOG_CORES-1:0]     debug_sel,
    output logic [4:0]               debug_addr,
    output logic                     debug_we,
    output logic                     debug_re,
    output logic [DATA_WIDTH-1:0]    debug_wdata,
    input  logic [DATA_WIDTH-1:0]    debug_rdata,
    output logic                     entropy_valid,
    input  logic                     entropy_ready,
    output logic [WB_WIDTH-1:0]      entropy_word
);
    localparam int DEPTH = 2 ** LOG_ENT_DEPTH;
    localparam int LW    = $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_e;
    typedef enum logic [1:0] {CH_PROG, CH_PADS, CH_DEBUG, CH_ENT} chan_e;

    state_e                 state_q;
    logic [WB_WIDTH-1:0]    req_adr_q, req_dat_q;
    logic                   req_we_q;
    logic [LW-1:0]          lat_q;
    logic                   ack_q;
    logic [WB_WIDTH-1:0]    dat_q;

    logic [WB_WIDTH-1:0]    fifo_mem [DEPTH];
    logic [LOG_ENT_DEPTH-1:0] wptr_q, rptr_q;
    logic [LOG_ENT_DEPTH:0] count_q, count_d;

    chan_e chan;
    logic  in_issue, in_wait, fifo_full, ent_wr, stall, push, pop, tmo_fire;
    logic  debug_hold;
    logic  unused_req;

    assign chan      = chan_e'(req_adr_q[WB_WIDTH-1 -: 2]);
    assign in_issue  = (state_q == S_ISSUE);
    assign in_wait   = (state_q == S_WAIT);
    // Full comes from the registered count, so a pop in the same cycle
    // does not release a stalled push until the next cycle.
    assign fifo_full = (count_q == (LOG_ENT_DEPTH+1)'(DEPTH));
    assign ent_wr    = in_issue && (chan == CH_ENT) && req_we_q;
    assign stall     = ent_wr && fifo_full;
    assign push      = ent_wr && !fifo_full;
    assign pop       = entropy_valid && entropy_ready;

`ifdef WB_MUX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    assign tmo_fire = (stall || in_wait) && (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)                          tmo_q <= '0;
        else if ((stall || in_wait) && !tmo_fire) tmo_q <= tmo_q + 1'b1;
        else                                   tmo_q <= '0;
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign tmo_fire = 1'b0;
`endif

    // NOTE: sequential state is written only with non-blocking assignments,
    // so every always_ff sees the pre-edge value of every other register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            req_adr_q <= '0;
            req_dat_q <= '0;
            req_we_q  <= 1'b0;
            lat_q     <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wbs_stb_i && wbs_cyc_i) begin
                        req_adr_q <= wbs_adr_i;
                        req_dat_q <= wbs_dat_i;
                        req_we_q  <= wbs_we_i;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (chan == CH_DEBUG && !req_we_q) begin
                        lat_q   <= LW'(READ_LAT);
                        state_q <= S_WAIT;
                    end else if (stall) begin
                        if (!wbs_cyc_i) begin
                            state_q <= S_IDLE;
                        end else if (tmo_fire) begin
                            dat_q   <= '1;
                            ack_q   <= 1'b1;
                            state_q <= S_ACK;
                        end
                    end else begin
                        dat_q   <= (chan == CH_ENT && !req_we_q) ? WB_WIDTH'(count_q) : '0;
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end
                end
                S_WAIT: begin
                    if (!wbs_cyc_i) begin
                        state_q <= S_IDLE;
                    end else if (lat_q == LW'(1)) begin
                        // Last wait cycle: debug_rdata is valid now.
                        dat_q   <= WB_WIDTH'(debug_rdata);
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else if (tmo_fire) begin
                        dat_q   <= '1;
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                S_ACK: begin
                    dat_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: count_d gets its default first, so no path through the case
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: the FIFO storage is not reset; count_q alone defines which
    // entries are live, and the head word is gated to zero while empty.
    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem[wptr_q] <= req_dat_q;
    end

    assign entropy_valid = (count_q != '0);
    assign entropy_word  = entropy_valid ? fifo_mem[rptr_q] : '0;

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    assign prog_we    = in_issue && (chan == CH_PROG) && req_we_q;
    assign prog_sel   = prog_we ? req_adr_q[PC_WIDTH +: LOG_CORES] : '0;
    assign prog_waddr = prog_we ? req_adr_q[PC_WIDTH-1:0] : '0;
    assign prog_wdata = prog_we ? req_dat_q[INSTR_WIDTH-1:0] : '0;

    assign pads_we    = in_issue && (chan == CH_PADS) && req_we_q;
    assign pads_waddr = pads_we && req_adr_q[0];
    assign pads_wdata = pads_we ? req_dat_q[IO_PINS-1:0] : '0;

    // The debugger sees its select/address for the whole transaction,
    // including the read-latency wait.
    assign debug_hold  = (in_issue || in_wait) && (chan == CH_DEBUG);
    assign debug_sel   = debug_hold ? req_adr_q[5 +: LOG_CORES] : '0;
    assign debug_addr  = debug_hold ? req_adr_q[4:0] : '0;
    assign debug_we    = in_issue && (chan == CH_DEBUG) && req_we_q;
    assign debug_re    = in_issue && (chan == CH_DEBUG) && !req_we_q;
    assign debug_wdata = debug_we ? req_dat_q[DATA_WIDTH-1:0] : '0;

    // Not every request bit reaches a channel for every parameter set.
    assign unused_req = ^{req_adr_q, req_dat_q};
endmodule

// File: tb/tb_wb_mux_seq.sv
// tb_wb_mux_seq -- self-checking bench for wb_mux_seq.
// Directed cases for reset, each channel, FIFO fill/drain, abort and
// push/pop, then randomized transactions against a queue-based model.
// Build with WB_MUX_TIMEOUT_EN defined to exercise the timeout path.
`timescale 1ns/1ps
module tb_wb_mux_seq;
    localparam int LOG_CORES = 3, PC_WIDTH = 8, INSTR_WIDTH = 32, DATA_WIDTH = 16;
    localparam int IO_PINS = 16, WB_WIDTH = 32, LOG_ENT_DEPTH = 2, DEPTH = 4;
`ifdef WB_MUX_TIMEOUT_EN
    localparam int READ_LAT = 20, TIMEOUT = 8;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int READ_LAT = 3, TIMEOUT = 255;
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat = '0;
    logic ack;
    logic [31:0] dat_o;
    logic prog_we, pads_we, pads_waddr, debug_we, debug_re, entropy_valid;
    logic entropy_ready = 1'b0;
    logic [2:0] prog_sel, debug_sel;
    logic [7:0] prog_waddr;
    logic [31:0] prog_wdata, entropy_word;
    logic [15:0] pads_wdata, debug_wdata;
    logic [15:0] debug_rdata = '0;
    logic [4:0] debug_addr;

    wb_mux_seq #(
        .LOG_CORES(LOG_CORES), .PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .IO_PINS(IO_PINS), .WB_WIDTH(WB_WIDTH),
        .READ_LAT(READ_LAT), .LOG_ENT_DEPTH(LOG_ENT_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack),
        .wbs_dat_o(dat_o), .prog_we(prog_we), .prog_sel(prog_sel),
        .prog_waddr(prog_waddr), .prog_wdata(prog_wdata), .pads_we(pads_we),
        .pads_waddr(pads_waddr), .pads_wdata(pads_wdata), .debug_sel(debug_sel),
        .debug_addr(debug_addr), .debug_we(debug_we), .debug_re(debug_re),
        .debug_wdata(debug_wdata), .debug_rdata(debug_rdata),
        .entropy_valid(entropy_valid), .entropy_ready(entropy_ready),
        .entropy_word(entropy_word)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // Observation and model state.
    int n_prog = 0, n_pads = 0, n_dwe = 0, n_dre = 0;
    logic [63:0] last_prog, last_pads, last_dwe, last_dre;
    logic [31:0] ent_model[$];
    logic [31:0] re_hist = '0;
    logic [15:0] dbg_val = 16'h0;
    int ready_mode = 0;   // 0 low, 1 high, 2 random, 3 single pulse
    int pulse_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: observe outputs before the edge, then update the debugger
    // and entropy-pool models one step after it.
    task automatic tick();
        logic re_now, gate_bad;
        re_now = debug_re;
        if (prog_we)  begin n_prog++; last_prog = {prog_sel, prog_waddr, prog_wdata}; end
        if (pads_we)  begin n_pads++; last_pads = {pads_waddr, pads_wdata}; end
        if (debug_we) begin n_dwe++;  last_dwe  = {debug_sel, debug_addr, debug_wdata}; end
        if (debug_re) begin n_dre++;  last_dre  = {debug_sel, debug_addr}; end
        gate_bad = (!prog_we && {prog_sel, prog_waddr, prog_wdata} != 0) ||
                   (!pads_we && {pads_waddr, pads_wdata} != 0) ||
                   (!debug_we && debug_wdata != 0);
        check("gating", gate_bad, 0);
        if (ent_model.size() == 0) check("ent_head", {entropy_valid, entropy_word}, 0);
        else                       check("ent_head", {entropy_valid, entropy_word}, {1'b1, ent_model[0]});
        if (entropy_valid && entropy_ready && ent_model.size() > 0) void'(ent_model.pop_front());
        @(posedge clk);
        #1;
        re_hist = {re_hist[30:0], re_now};
        debug_rdata = re_hist[READ_LAT-1] ? dbg_val : ~dbg_val;
        case (ready_mode)
            0: entropy_ready = 1'b0;
            1: entropy_ready = 1'b1;
            2: entropy_ready = ($urandom % 4) != 0;
            default: begin pulse_cnt--; entropy_ready = (pulse_cnt == 0); end
        endcase
    endtask

    task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic acked, output logic [31:0] rd,
                            output int cycles, output int fill);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d;
        acked = 1'b0; rd = '0; cycles = 0; fill = -1;
        while (!acked && cycles < 200) begin
            if (cycles == 1) fill = ent_model.size();
            tick();
            cycles++;
            if (ack) begin acked = 1'b1; rd = dat_o; end
        end
        stb = 1'b0; cyc = 1'b0;
        if (acked && w && a[31:30] == 2'b11 && rd != 32'hFFFF_FFFF) ent_model.push_back(d);
    endtask

    // Full transaction with expectations derived from the channel rules.
    task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd);
        logic acked;
        int cycles, fill, p0, s0, dw0, dr0;
        p0 = n_prog; s0 = n_pads; dw0 = n_dwe; dr0 = n_dre;
        wb_cycle(w, a, d, acked, rd, cycles, fill);
        check("ack", acked, 1);
        case (a[31:30])
            2'b00: begin
                check("prog_cnt", n_prog - p0, w ? 1 : 0);
                if (w) check("prog_fld", last_prog, {a[10:8], a[7:0], d});
                check("prog_cyc", cycles, 2);
                check("prog_rd", rd, 0);
            end
            2'b01: begin
                check("pads_cnt", n_pads - s0, w ? 1 : 0);
                if (w) check("pads_fld", last_pads, {a[0], d[15:0]});
                check("pads_cyc", cycles, 2);
                check("pads_rd", rd, 0);
            end
            2'b10: begin
                if (w) begin
                    check("dwe_cnt", n_dwe - dw0, 1);
                    check("dwe_fld", last_dwe, {a[7:5], a[4:0], d[15:0]});
                    check("dwe_cyc", cycles, 2);
                    check("dwe_rd", rd, 0);
                end else begin
                    check("dre_cnt", n_dre - dr0, 1);
                    check("dre_fld", last_dre, {a[7:5], a[4:0]});
                    if (TMO_EN && READ_LAT > TIMEOUT) begin
                        check("dre_cyc", cycles, 2 + TIMEOUT);
                        check("dre_rd", rd, 32'hFFFF_FFFF);
                    end else begin
                        check("dre_cyc", cycles, 2 + READ_LAT);
                        check("dre_rd", rd, {16'h0, dbg_val});
                    end
                end
            end
            default: begin
                if (w) begin
                    if (fill < DEPTH) check("ent_wcyc", cycles, 2);
                    check("ent_wrd", rd, 0);
                end else begin
                    check("ent_cnt", rd, fill);
                    check("ent_rcyc", cycles, 2);
                end
            end
        endcase
        tick();
        check("ack_1cyc", {ack, dat_o}, 0);
    endtask

    initial begin
        logic [31:0] rd, tmp;
        logic acked;
        int cycles, fill;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ack", {ack, dat_o}, 0);
        check("rst_strobes", {prog_we, pads_we, debug_we, debug_re, entropy_valid}, 0);
        check("rst_word", entropy_word, 0);
        tick();

        // Channel basics.
        do_op(1'b1, 32'h0000_0305, 32'hDEAD_BEEF, rd);
        check("prog_example", last_prog, {3'd3, 8'h05, 32'hDEAD_BEEF});
        do_op(1'b1, 32'h4000_0001, 32'hABCD_1234, rd);
        do_op(1'b0, 32'h4000_0000, 32'h0, rd);
        do_op(1'b1, 32'h8000_0067, 32'h0000_5A5A, rd);
        dbg_val = 16'h1234;
        do_op(1'b0, 32'h8000_0042, 32'h0, rd);
        check("dbg_example", last_dre, {3'd2, 5'd2});
`ifdef WB_MUX_TIMEOUT_EN
        check("timeout_data", rd, 32'hFFFF_FFFF);
`else
        check("dbg_data", rd, 32'h0000_1234);
`endif

        // Fill to depth, stall the fifth write until one pop.
        ready_mode = 0;
        for (int i = 1; i <= 4; i++) do_op(1'b1, 32'hC000_0000, 32'h1000_0000 + i, rd);
        ready_mode = 3; pulse_cnt = 5;
        wb_cycle(1'b1, 32'hC000_0000, 32'h1000_0005, acked, rd, cycles, fill);
        check("stall_ack", acked, 1);
        check("stall_cyc", cycles, 7);
        ready_mode = 0;
        tick();
        do_op(1'b0, 32'hC000_0000, 32'h0, rd);
        check("fill4", rd, 4);
        ready_mode = 1;
        repeat (6) tick();
        check("drained", entropy_valid, 0);

        // Abort during a full-FIFO stall.
        ready_mode = 0;
        tick();
        for (int i = 0; i < 4; i++) do_op(1'b1, 32'hC000_0010, 32'h2000_0000 + i, rd);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'hC000_0000; dat = 32'hBAD0_BAD0;
        repeat (3) begin tick(); check("abort_noack", ack, 0); end
        stb = 1'b0; cyc = 1'b0;
        repeat (3) begin tick(); check("abort_noack", ack, 0); end
        do_op(1'b0, 32'hC000_0000, 32'h0, rd);
        check("abort_cnt", rd, 4);

        // Push and pop in the same cycle at count 2.
        ready_mode = 1;
        repeat (6) tick();
        ready_mode = 0;
        tick();
        do_op(1'b1, 32'hC000_0000, 32'h3000_0001, rd);
        do_op(1'b1, 32'hC000_0000, 32'h3000_0002, rd);
        ready_mode = 3; pulse_cnt = 1;
        do_op(1'b1, 32'hC000_0000, 32'h3000_0003, rd);
        ready_mode = 0;
        tick();
        do_op(1'b0, 32'hC000_0000, 32'h0, rd);
        check("pushpop_cnt", rd, 2);

        // Reset while a debug read is waiting.
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h8000_0021; dat = '0;
        tick();
        tick();
        check("wait_hold", {debug_sel, debug_addr}, {3'd1, 5'd1});
        rst = 1'b1; stb = 1'b0; cyc = 1'b0;
        tick();
        ent_model.delete();
        check("rst_wait_ack", {ack, dat_o}, 0);
        check("rst_wait_fifo", {entropy_valid, entropy_word}, 0);
        check("rst_wait_dbg", {debug_sel, debug_addr, debug_re}, 0);
        rst = 1'b0;
        tick();
        do_op(1'b0, 32'hC000_0000, 32'h0, rd);
        check("rst_cnt", rd, 0);

        // Randomized traffic.
        ready_mode = TMO_EN ? 1 : 2;
        for (int i = 0; i < 40; i++) begin
            tmp = $urandom;
            dbg_val = 16'($urandom);
            do_op(1'($urandom % 2), tmp, $urandom, rd);
            repeat ($urandom % 3) begin tick(); check("idle_ack", ack, 0); end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
